// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and geometry helpers for the direct-mapped
// write-through cache.
package cache_pkg;

  localparam int ADR_W  = 8;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WRITE = 2'd2
  } state_e;

  function automatic int tag_w(input int index_bits);
    return ADR_W - index_bits;
  endfunction

  function automatic int num_lines(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU load/store port and off-chip memory port of the cache, bundled together.
interface cache_if;
  import cache_pkg::*;

  logic [ADR_W-1:0]  cpu_adr;
  logic              cpu_read_en;
  logic              cpu_write_en;
  logic [DATA_W-1:0] cpu_write_data;
  logic [DATA_W-1:0] cpu_read_data;
  logic              stall;
  logic [ADR_W-1:0]  mem_adr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic [15:0]       miss_count;

  // Master: CPU plus memory model; slave: the cache controller.
  modport master (
    output cpu_adr, cpu_read_en, cpu_write_en, cpu_write_data, mem_read_data,
    input  cpu_read_data, stall, mem_adr, mem_read_en, mem_write_en,
           mem_write_data, miss_count
  );

  modport slave (
    input  cpu_adr, cpu_read_en, cpu_write_en, cpu_write_data, mem_read_data,
    output cpu_read_data, stall, mem_adr, mem_read_en, mem_write_en,
           mem_write_data, miss_count
  );

endinterface

// File: rtl/cache_array.sv
// Valid/tag/data storage: combinational lookup, one synchronous write port,
// valid bits cleared by synchronous reset.
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INDEX_BITS-1:0]         lk_idx_i,
  input  logic [tag_w(INDEX_BITS)-1:0]  lk_tag_i,
  output logic                          hit_o,
  output logic [DATA_W-1:0]             data_o,
  input  logic                          wr_en_i,
  input  logic [INDEX_BITS-1:0]         wr_idx_i,
  input  logic [tag_w(INDEX_BITS)-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0]             wr_data_i
);

  localparam int TAG_W = tag_w(INDEX_BITS);
  localparam int LINES = num_lines(INDEX_BITS);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_comb begin
    hit_o  = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    data_o = data_q[lk_idx_i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// fixed-latency memory port and a read-miss counter.
module cache_controller
  import cache_pkg::*;
#(
  parameter int INDEX_BITS  = 4,
  parameter int MEM_LATENCY = 4
) (
  input logic    clk,
  input logic    rst,
  cache_if.slave bus
);

  localparam int TAG_W = tag_w(INDEX_BITS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       miss_count_q;

  logic [ADR_W-1:0]  lk_adr_s;
  logic              hit_s;
  logic [DATA_W-1:0] line_data_s;
  logic              last_s;
  logic              arr_we_s;
  logic [DATA_W-1:0] arr_wdata_s;

  // In WRITE the hit check must use the latched address, not the live bus.
  assign lk_adr_s = (state_q == IDLE) ? bus.cpu_adr : adr_q;
  assign last_s   = (cnt_q == LAST_CNT);

  cache_array #(.INDEX_BITS(INDEX_BITS)) u_array (
    .clk       (clk),
    .rst       (rst),
    .lk_idx_i  (lk_adr_s[INDEX_BITS-1:0]),
    .lk_tag_i  (lk_adr_s[ADR_W-1:INDEX_BITS]),
    .hit_o     (hit_s),
    .data_o    (line_data_s),
    .wr_en_i   (arr_we_s),
    .wr_idx_i  (adr_q[INDEX_BITS-1:0]),
    .wr_tag_i  (adr_q[ADR_W-1:INDEX_BITS]),
    .wr_data_i (arr_wdata_s)
  );

  always_comb begin
    arr_we_s    = 1'b0;
    arr_wdata_s = wdata_q;
    if (!rst && last_s) begin
      if (state_q == RMISS) begin
        arr_we_s    = 1'b1;
        arr_wdata_s = bus.mem_read_data;
      end else if (state_q == WRITE) begin
        arr_we_s    = hit_s;
      end else begin
        arr_we_s    = 1'b0;
      end
    end else begin
      arr_we_s = 1'b0;
    end
  end

  always_comb begin
    bus.mem_adr        = bus.cpu_adr;
    bus.mem_read_en    = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_write_data = bus.cpu_write_data;
    bus.stall          = 1'b0;
    bus.cpu_read_data  = '0;
    case (state_q)
      IDLE: begin
        bus.stall = bus.cpu_write_en || (bus.cpu_read_en && !hit_s);
        if (!bus.cpu_write_en && bus.cpu_read_en && hit_s) begin
          bus.cpu_read_data = line_data_s;
        end else begin
          bus.cpu_read_data = '0;
        end
      end
      RMISS: begin
        bus.mem_adr     = adr_q;
        bus.mem_read_en = 1'b1;
        bus.stall       = 1'b1;
      end
      WRITE: begin
        bus.mem_adr        = adr_q;
        bus.mem_write_data = wdata_q;
        bus.mem_write_en   = last_s;
        bus.stall          = !last_s;
      end
      default: begin
        bus.stall = 1'b0;
      end
    endcase
  end

  assign bus.miss_count = miss_count_q;

  // Control FSM; cnt restarts on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      adr_q        <= '0;
      wdata_q      <= '0;
      miss_count_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.cpu_write_en) begin
            state_q <= WRITE;
            adr_q   <= bus.cpu_adr;
            wdata_q <= bus.cpu_write_data;
          end else if (bus.cpu_read_en && !hit_s) begin
            state_q      <= RMISS;
            adr_q        <= bus.cpu_adr;
            miss_count_q <= miss_count_q + 16'd1;
          end
        end
        RMISS, WRITE: begin
          if (last_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed plus randomized bench for cache_controller against an
// address-level model of a direct-mapped write-through cache.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  cache_if bus ();

  cache_controller #(.INDEX_BITS(4), .MEM_LATENCY(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    if (a == 8'h13) return 16'hBEEF;
    if (a == 8'h23) return 16'h1234;
    return 16'((a * 40503) ^ 16'h5A5A);
  endfunction

  // Off-chip memory: combinational read, write on the clock edge.
  logic [15:0] mem [256];
  assign bus.mem_read_data = mem[bus.mem_adr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.mem_write_en) mem[bus.mem_adr] = bus.mem_write_data;
    end
  end

  // Reference model: which address each line holds, and the word it holds.
  logic [15:0] ref_mem   [256];
  bit          line_ok   [16];
  logic [7:0]  line_adr  [16];
  logic [15:0] line_data [16];
  int          ref_miss;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) line_ok[i] = 1'b0;
    ref_miss = 0;
  endtask

  task automatic model_read(input logic [7:0] a, output bit hit, output logic [15:0] d);
    int idx = int'(a) % 16;
    hit = line_ok[idx] && line_adr[idx] == a;
    if (!hit) begin
      ref_miss = (ref_miss + 1) % 65536;
      line_ok[idx] = 1'b1;
      line_adr[idx] = a;
      line_data[idx] = ref_mem[a];
    end
    d = line_data[idx];
  endtask

  task automatic model_write(input logic [7:0] a, input logic [15:0] d);
    int idx = int'(a) % 16;
    ref_mem[a] = d;
    if (line_ok[idx] && line_adr[idx] == a) line_data[idx] = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input string tag);
    bit hit;
    logic [15:0] exp_d;
    logic [15:0] got = 16'h0;
    int stalls = 0, rds = 0;
    bit done = 1'b0;
    model_read(a, hit, exp_d);
    bus.cpu_adr = a; bus.cpu_read_en = 1'b1; bus.cpu_write_en = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_read_en) rds++;
      if (bus.stall) stalls++;
      else begin got = bus.cpu_read_data; done = 1'b1; end
      @(posedge clk); #1;
    end
    bus.cpu_read_en = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall"}, 32'(stalls), hit ? 32'd0 : 32'd5);
    chk({tag, " rd_en"}, 32'(rds), hit ? 32'd0 : 32'd4);
    chk({tag, " data"}, 32'(got), 32'(exp_d));
    chk({tag, " misses"}, 32'(bus.miss_count), 32'(ref_miss));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input bit both, input string tag);
    int stalls = 0, rds = 0, wrs = 0;
    logic [7:0] wa = 8'h0;
    logic [15:0] wd = 16'h0;
    bit done = 1'b0;
    model_write(a, d);
    bus.cpu_adr = a; bus.cpu_write_data = d;
    bus.cpu_write_en = 1'b1; bus.cpu_read_en = both;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_read_en) rds++;
      if (bus.mem_write_en) begin wrs++; wa = bus.mem_adr; wd = bus.mem_write_data; end
      if (bus.stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stall"}, 32'(stalls), 32'd4);
    chk({tag, " wr_pulses"}, 32'(wrs), 32'd1);
    chk({tag, " rd_en"}, 32'(rds), 32'd0);
    chk({tag, " wr_adr"}, 32'(wa), 32'(a));
    chk({tag, " wr_data"}, 32'(wd), 32'(d));
    chk({tag, " mem"}, 32'(mem[a]), 32'(d));
    chk({tag, " misses"}, 32'(bus.miss_count), 32'(ref_miss));
  endtask

  logic [7:0] pool [12] = '{8'h03, 8'h13, 8'h23, 8'h33, 8'h05, 8'h45,
                            8'hA5, 8'h7F, 8'h8F, 8'h01, 8'h11, 8'hFE};

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    bus.cpu_adr = 8'h0; bus.cpu_read_en = 1'b0; bus.cpu_write_en = 1'b0;
    bus.cpu_write_data = 16'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst stall", 32'(bus.stall), 32'd0);
    chk("rst mem_read_en", 32'(bus.mem_read_en), 32'd0);
    chk("rst mem_write_en", 32'(bus.mem_write_en), 32'd0);
    chk("rst miss_count", 32'(bus.miss_count), 32'd0);
    chk("rst read_data", 32'(bus.cpu_read_data), 32'd0);
    @(posedge clk); #1;

    do_read(8'h13, "t1 miss");
    do_read(8'h13, "t1 hit");
    do_read(8'h23, "t2 evict");
    do_read(8'h13, "t2 refill");
    chk("t2 miss_count3", 32'(bus.miss_count), 32'd3);
    do_write(8'h13, 16'hCAFE, 1'b0, "t3 wr_hit");
    do_read(8'h13, "t3 rd");
    do_write(8'h45, 16'h5A5A, 1'b0, "t4 wr_miss");
    do_read(8'h45, "t4 rd");

    // Reset during the second RMISS cycle of a read of 0x7F.
    bus.cpu_adr = 8'h7F; bus.cpu_read_en = 1'b1;
    @(negedge clk);
    chk("t5 detect stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5 rmiss rd_en", 32'(bus.mem_read_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5 idle miss stall", 32'(bus.stall), 32'd1);
    chk("t5 mem_read_en", 32'(bus.mem_read_en), 32'd0);
    chk("t5 miss_count", 32'(bus.miss_count), 32'd0);
    bus.cpu_read_en = 1'b0;
    #1 chk("t5 no req stall", 32'(bus.stall), 32'd0);
    model_reset();
    do_read(8'h7F, "t5 reread");
    do_read(8'h13, "t5 invalid");

    do_write(8'h01, 16'h0042, 1'b1, "t6 both");
    do_read(8'h01, "t6 rd");

    for (int n = 0; n < 150; n++) begin
      logic [7:0] a = pool[$urandom_range(0, 11)];
      int kind = $urandom_range(0, 9);
      if (kind < 6) do_read(a, "rnd rd");
      else do_write(a, 16'($urandom), kind == 9, "rnd wr");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate cache between the 16-bit MIPS datapath's load/store unit and the 256×16 word memory. A read hit returns data combinationally with no stall. A read miss stalls the CPU, fetches the word over a fixed-latency off-chip memory interface, fills the line and then completes as a hit. Every write goes to memory, and a write also updates the line if it is resident.

## Interface
Parameters:
- INDEX_BITS, 4: number of index bits. Lines = 2^INDEX_BITS. Tag = 8−INDEX_BITS bits.
- MEM_LATENCY, 4: cycles per off-chip access. Must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_adr  in  8  word address from the CPU. Held stable while stall=1.
- cpu_read_en  in  1  load request.
- cpu_write_en  in  1  store request. Has priority over cpu_read_en.
- cpu_write_data  in  16  store data.
- cpu_read_data  out  16  load data. Valid when cpu_read_en=1 and stall=0. Otherwise 16'b0.
- stall  out  1  CPU must hold its request and freeze.
- mem_adr  out  8  memory word address.
- mem_read_en  out  1  memory read enable.
- mem_write_en  out  1  memory write enable. Single-cycle pulse.
- mem_write_data  out  16  memory write data.
- mem_read_data  in  16  memory read data (combinational from memory).
- miss_count  out  16  read-miss counter. Wraps at 2^16.

## Operation
- Line contents: valid bit, tag = cpu_adr[7:INDEX_BITS], 16-bit data word. Index = cpu_adr[INDEX_BITS-1:0].
- Hit condition: valid[index] && tag[index]==cpu_adr tag.
- FSM states: IDLE, RMISS, WRITE. A counter cnt counts 0..MEM_LATENCY−1 and is zeroed on every state entry.
- In IDLE:
  - Write request: go to WRITE. Latch adr and data.
  - Read miss: go to RMISS. Latch adr. miss_count+1.
  - Read hit: cpu_read_data = line data, stall=0.
  - No request: stay in IDLE.
  - stall = write request || read miss (combinational).
- In RMISS:
  - Outputs: mem_read_en=1, mem_adr=latched adr, stall=1.
  - On the edge that ends cnt==MEM_LATENCY−1: write mem_read_data into the line, set valid and tag, go to IDLE.
  - The held request then hits.
- In WRITE:
  - Outputs: mem_adr=latched adr, mem_write_data=latched data.
  - mem_write_en=1 only while cnt==MEM_LATENCY−1.
  - stall = (cnt != MEM_LATENCY−1).
  - On the final edge: if the line hits on the latched adr, update its data. Never allocate on a write miss. Go to IDLE.
- Outside RMISS/WRITE: mem_adr=cpu_adr, mem_read_en=0, mem_write_en=0, mem_write_data=cpu_write_data.
- Reset: at the first rising edge with rst=1, the block sets:
  - state=IDLE, cnt=0
  - all valid bits cleared
  - miss_count=0
  - latches cleared.
- Reset mid-operation: any RMISS/WRITE in progress is abandoned. No line fill and no mem_write_en pulse occur after that edge.

## Timing
- Read hit: 0 stall cycles. Data is available in the request cycle.
- Read miss: stall is high for MEM_LATENCY+1 cycles (1 IDLE detect cycle + MEM_LATENCY RMISS cycles). Data is returned in the following IDLE cycle with stall=0.
- Write (hit or miss): stall is high for MEM_LATENCY cycles. The CPU advances at the edge ending the final WRITE cycle, where mem_write_en=1.
- Exactly one mem_write_en pulse per store.
- Back-to-back requests: the first cycle after returning to IDLE evaluates the new request with no bubble.
- Post-reset outputs: mem_read_en=0, mem_write_en=0, miss_count=0. stall=0 unless a request is present; any read is a miss because all lines are invalid.

## Structure
- Shared package cache_pkg holds:
  - ADR_W=8, DATA_W=16
  - state encoding IDLE/RMISS/WRITE
  - tag/index width functions of INDEX_BITS.
- One sub-module, cache_array, holds valid, tag and data storage. It has:
  - combinational lookup (hit, data) on an index/tag pair
  - synchronous fill/update write port
  - synchronous valid clear on rst.
- The FSM, counter, latches and miss_count live in cache_controller.

## Test plan
Bench setup: INDEX_BITS=4, MEM_LATENCY=4, memory model attached.

1. After reset, read 0x13 with mem[0x13]=0xBEEF.
   - stall high 5 cycles, mem_read_en high 4 cycles.
   - Then cpu_read_data=0xBEEF with stall=0. miss_count=1.
   - Immediate re-read of 0x13: hit in the same cycle, no mem_read_en.
2. Read 0x23 (same index 3, mem=0x1234), then 0x13.
   - Both miss; 0x23 evicts 0x13.
   - Data 0x1234 then 0xBEEF. miss_count=3.
3. Store 0xCAFE to resident 0x13.
   - stall high 4 cycles.
   - One mem_write_en pulse with mem_adr=0x13, mem_write_data=0xCAFE.
   - Next read of 0x13 hits with 0xCAFE.
4. Store 0x5A5A to non-resident 0x45.
   - Memory is updated; no allocation.
   - Following read of 0x45 misses and returns 0x5A5A.
5. Assert rst during the 2nd RMISS cycle for 0x7F.
   - Next cycle: IDLE, mem_read_en=0, miss_count=0, all lines invalid.
   - Re-read 0x7F misses.
6. cpu_read_en=cpu_write_en=1 at 0x01 with data 0x0042.
   - Treated as a store: one mem_write_en pulse, no RMISS, miss_count unchanged.
